// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
// inst_fetch: owns the PC, issues single-outstanding word reads, buffers returned instructions in a 2-entry queue.
// Latency: accept at n -> imem_rvalid at n+1 -> inst_valid at n+2 with a 1-cycle memory.
// Backpressure: requests stop once buffered plus in-flight instructions would reach 2; redirect flushes and drops in-flight data.
module inst_fetch #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redir_valid,
  input  logic [PC_W-1:0]   redir_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready
);

  // IDLE: nothing outstanding; WAIT: outstanding, keep data; DROP: outstanding, discard data
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   req_pc;   // PC of the read currently outstanding
  logic [1:0]        count;
  logic [PC_W-1:0]   q0_pc, q1_pc;
  logic [INST_W-1:0] q0_inst, q1_inst;

  logic       pop;
  logic       push;
  logic       accept;
  logic [2:0] occ;

  assign inst_valid = (count != 2'd0);
  assign inst       = q0_inst;
  assign inst_pc    = q0_pc;
  assign imem_addr  = pc;

  // Request gating: occupancy counts the kept in-flight read so the queue can never overflow
  always_comb begin
    pop      = inst_valid & inst_ready;
    occ      = 3'(count) + 3'(state == WAIT) - 3'(pop);
    imem_req = !redir_valid && (occ < 3'd2) && ((state == IDLE) || imem_rvalid);
    accept   = imem_req & imem_gnt;
    push     = (state == WAIT) & imem_rvalid & !redir_valid;
  end

  // PC and outstanding-read tracking; redirect overrides everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redir_valid) begin
      pc <= redir_pc;
      // a read still in flight must have its late response thrown away
      state <= ((state != IDLE) && !imem_rvalid) ? DROP : IDLE;
    end else if (accept) begin
      pc     <= pc + PC_W'(1);
      req_pc <= pc;
      state  <= WAIT;
    end else if ((state != IDLE) && imem_rvalid) begin
      state <= IDLE;
    end
  end

  // Two-entry prefetch queue; head is always q0 so outputs come straight from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      q0_pc   <= '0;
      q0_inst <= '0;
      q1_pc   <= '0;
      q1_inst <= '0;
    end else if (redir_valid) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q0_pc   <= req_pc;
            q0_inst <= imem_rdata;
          end else begin
            q1_pc   <= req_pc;
            q1_inst <= imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q0_pc   <= q1_pc;
          q0_inst <= q1_inst;
          count   <= count - 2'd1;
        end
        2'b11: begin
          // count stays the same; the new entry lands behind whatever remains
          if (count == 2'd1) begin
            q0_pc   <= req_pc;
            q0_inst <= imem_rdata;
          end else begin
            q0_pc   <= q1_pc;
            q0_inst <= q1_inst;
            q1_pc   <= req_pc;
            q1_inst <= imem_rdata;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
// Testbench for inst_fetch: randomized and directed stimulus with a scoreboard.
// Expected {pc, data} entries are queued when a request is accepted; a monitor pops them on each handshake.
// Memory model returns addr ^ 16'hA5A5 after a programmable latency.
module tb_inst_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  int          checks = 0;
  int          errors = 0;
  int          lat    = 1;
  logic [31:0] exp_q[$];
  logic [15:0] mdl_addr = RST_PC;

  inst_fetch #(.PC_W(16), .INST_W(16), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: inst_valid 0 after 50 cycles, required 1", name);
    end
  endtask

  // Memory model: one outstanding read, data = addr ^ A5A5 after 'lat' cycles
  initial begin
    logic        pend;
    int          cnt;
    logic [15:0] d;
    logic        acc;
    logic [15:0] a;
    pend = 1'b0; cnt = 0; d = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc = rst_n && imem_req && imem_gnt;
      a   = imem_addr;
      @(posedge clk);
      #1;
      if (acc) begin
        pend = 1'b1;
        cnt  = lat;
        d    = a ^ 16'hA5A5;
      end
      imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = d;
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Reference model: next fetch address and expected instruction stream
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        mdl_addr = RST_PC;
      end else if (redir_valid) begin
        chk("req_during_redirect", imem_req, 0);
        exp_q.delete();
        mdl_addr = redir_pc;
      end else if (imem_req && imem_gnt) begin
        chk("req_addr", imem_addr, mdl_addr);
        exp_q.push_back({mdl_addr, mdl_addr ^ 16'hA5A5});
        mdl_addr = mdl_addr + 16'd1;
      end
    end
  end

  // Monitor: compare every consumed instruction against the scoreboard head
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (dut.count > 2'd2 || (dut.push && dut.count == 2'd2)) begin
          errors++;
          $display("FAIL queue_bound: count %0d push %0d, required count<=2 and no push when full",
                   dut.count, dut.push);
        end
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got pc %h inst %h, required no instruction", inst_pc, inst);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", inst_pc, e[31:16]);
            chk("pop_inst", inst, e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] diff;
    rst_n = 1'b0; imem_gnt = 1'b0; redir_valid = 1'b0; redir_pc = '0; inst_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_addr", imem_addr, RST_PC);

    // Reset then stream
    @(posedge clk);
    #1;
    rst_n = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    chk("req_after_rst", imem_req, 1);
    @(negedge clk); chk("fill_c0", inst_valid, 0);
    @(negedge clk); chk("fill_c1", inst_valid, 0);
    @(negedge clk); chk("fill_c2", inst_valid, 1);
    repeat (15) begin
      @(negedge clk);
      chk("stream_gap", inst_valid, 1);
    end

    // Backpressure
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    diff = imem_addr - inst_pc;
    chk("bp_valid", inst_valid, 1);
    chk("bp_req", imem_req, 0);
    chk("bp_count", dut.count, 2);
    chk("bp_pc_adv", diff, 2);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("drain_gap", inst_valid, 1);
    end

    // Redirect while a 3-cycle read of 0x0005 is outstanding
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    lat = 3; imem_gnt = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0005;
    @(posedge clk); #1; redir_valid = 1'b0;
    @(posedge clk); #1; redir_valid = 1'b1; redir_pc = 16'h0100;
    @(posedge clk); #1; redir_valid = 1'b0;
    wait_valid("redir_inflight");
    chk("redir_first_pc", inst_pc, 16'h0100);

    // Redirect coincident with response and pop
    lat = 1;
    repeat (8) @(posedge clk);
    #1;
    redir_valid = 1'b1; redir_pc = 16'h0200;
    @(negedge clk);
    chk("coinc_rvalid", imem_rvalid, 1);
    chk("coinc_pop", inst_valid & inst_ready, 1);
    @(posedge clk); #1; redir_valid = 1'b0;
    @(negedge clk);
    chk("coinc_flush", inst_valid, 0);
    wait_valid("coinc");
    chk("coinc_next_pc", inst_pc, 16'h0200);

    // Grant stall holds the address, then wrap through 0xFFFF
    repeat (4) @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, mdl_addr);
    end
    @(posedge clk); #1; imem_gnt = 1'b1; redir_valid = 1'b1; redir_pc = 16'hFFFF;
    @(posedge clk); #1; redir_valid = 1'b0;
    wait_valid("wrap");
    chk("wrap0", inst_pc, 16'hFFFF);
    @(negedge clk); chk("wrap1", inst_pc, 16'h0000);
    @(negedge clk); chk("wrap2", inst_pc, 16'h0001);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      imem_gnt    = ($urandom_range(0, 3) != 0);
      inst_ready  = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 39) == 0);
      redir_pc    = 16'($urandom_range(0, 65535));
      lat         = int'($urandom_range(1, 3));
    end

    // Async reset between accept and response
    @(posedge clk);
    #1;
    redir_valid = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b1; lat = 3;
    repeat (6) @(posedge clk);
    #1;
    imem_gnt = 1'b1;
    @(posedge clk); #1; imem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", inst_valid, 0);
    chk("arst_inst", inst, 0);
    chk("arst_inst_pc", inst_pc, 0);
    chk("arst_addr", imem_addr, RST_PC);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stale_ignored", inst_valid, 0);
    @(posedge clk); #1; imem_gnt = 1'b1;
    wait_valid("restart");
    chk("restart_pc", inst_pc, RST_PC);
    chk("restart_inst", inst, RST_PC ^ 16'hA5A5);

    // Drain and confirm nothing expected was lost
    @(posedge clk);
    #1;
    imem_gnt = 1'b0; inst_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
